// File: rtl/lsu_seq.sv
// Byte-serial load/store sequencer: moves 1, 2 or 4 bytes big-endian between the
// cpu datapath and a byte-wide memory with separate read and write addresses.
module lsu_seq #(
   parameter int addr_width   = 9,
   parameter int read_latency = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  write,
   input  logic [1:0]            size,
   input  logic                  sign,
   input  logic [addr_width-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [addr_width-1:0] mem_raddr,
   input  logic [7:0]            mem_data_out,
   output logic [addr_width-1:0] mem_waddr,
   output logic [7:0]            mem_data_in,
   output logic                  mem_write
);

   // Handshake: a request is taken on any edge with req=1 and busy=0 (including
   // the done cycle); done is a one-cycle pulse, err accompanies it for size=3.
   typedef enum logic [1:0] {IDLE, READ, WSETUP, WSTROBE} state_t;

   localparam logic [1:0] lat_init = 2'(read_latency - 1);

   state_t                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  mem_write_q, mem_write_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [addr_width-1:0] mem_raddr_q, mem_raddr_d;
   logic [addr_width-1:0] mem_waddr_q, mem_waddr_d;
   logic [7:0]            mem_data_in_q, mem_data_in_d;
   logic [addr_width-1:0] base_q, base_d;
   logic [1:0]            size_q, size_d;
   logic                  sign_q, sign_d;
   logic [1:0]            k_q, k_d;
   logic [1:0]            lat_q, lat_d;
   logic [31:0]           sh_q, sh_d;

   logic [1:0]            k_next;
   logic [addr_width-1:0] addr_next;
   logic                  last;
   logic [31:0]           assembled;
   logic [31:0]           aligned;

   function automatic logic [1:0] last_index(input logic [1:0] sz);
      case (sz)
         2'd0:    last_index = 2'd0;
         2'd1:    last_index = 2'd1;
         default: last_index = 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] sz,
                                          input logic sgn);
      case (sz)
         2'd0:    extend = sgn ? {{24{a[7]}}, a[7:0]} : {24'h0, a[7:0]};
         2'd1:    extend = sgn ? {{16{a[15]}}, a[15:0]} : {16'h0, a[15:0]};
         default: extend = a;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      mem_write_d   = mem_write_q;
      rdata_d       = rdata_q;
      mem_raddr_d   = mem_raddr_q;
      mem_waddr_d   = mem_waddr_q;
      mem_data_in_d = mem_data_in_q;
      base_d        = base_q;
      size_d        = size_q;
      sign_d        = sign_q;
      k_d           = k_q;
      lat_d         = lat_q;
      sh_d          = sh_q;

      k_next    = k_q + 2'd1;
      addr_next = base_q + addr_width'(k_next);
      last      = (k_q == last_index(size_q));
      assembled = {sh_q[23:0], mem_data_out};

      // Store data is left-justified so the first byte out is always sh[31:24].
      case (size)
         2'd0:    aligned = {wdata[7:0], 24'h0};
         2'd1:    aligned = {wdata[15:0], 16'h0};
         default: aligned = wdata;
      endcase

      case (state_q)
         IDLE: begin
            if (req) begin
               base_d = addr;
               size_d = size;
               sign_d = sign;
               k_d    = 2'd0;
               if (size == 2'd3) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else if (write) begin
                  mem_waddr_d   = addr;
                  mem_data_in_d = aligned[31:24];
                  sh_d          = {aligned[23:0], 8'h0};
                  mem_write_d   = 1'b0;
                  busy_d        = 1'b1;
                  state_d       = WSETUP;
               end else begin
                  mem_raddr_d = addr;
                  lat_d       = lat_init;
                  sh_d        = 32'h0;
                  busy_d      = 1'b1;
                  state_d     = READ;
               end
            end
         end
         READ: begin
            if (lat_q == 2'd0) begin
               sh_d = assembled;
               if (last) begin
                  rdata_d = extend(assembled, size_q, sign_q);
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  k_d         = k_next;
                  mem_raddr_d = addr_next;
                  lat_d       = lat_init;
               end
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         WSETUP: begin
            mem_write_d = 1'b1;
            state_d     = WSTROBE;
         end
         WSTROBE: begin
            mem_write_d = 1'b0;
            if (last) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               k_d           = k_next;
               mem_waddr_d   = addr_next;
               mem_data_in_d = sh_q[31:24];
               sh_d          = {sh_q[23:0], 8'h0};
               state_d       = WSETUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         mem_write_q   <= 1'b0;
         rdata_q       <= 32'h0;
         mem_raddr_q   <= '0;
         mem_waddr_q   <= '0;
         mem_data_in_q <= 8'h0;
         base_q        <= '0;
         size_q        <= 2'd0;
         sign_q        <= 1'b0;
         k_q           <= 2'd0;
         lat_q         <= 2'd0;
         sh_q          <= 32'h0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         mem_write_q   <= mem_write_d;
         rdata_q       <= rdata_d;
         mem_raddr_q   <= mem_raddr_d;
         mem_waddr_q   <= mem_waddr_d;
         mem_data_in_q <= mem_data_in_d;
         base_q        <= base_d;
         size_q        <= size_d;
         sign_q        <= sign_d;
         k_q           <= k_d;
         lat_q         <= lat_d;
         sh_q          <= sh_d;
      end
   end

   assign rdata       = rdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign mem_raddr   = mem_raddr_q;
   assign mem_waddr   = mem_waddr_q;
   assign mem_data_in = mem_data_in_q;
   assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: one instance at read_latency=2 and one at 3, each
// with a small read memory model and a log of observed write strobes.
module tb_lsu_seq;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance A: read_latency = 2
   logic        req_a = 1'b0, write_a = 1'b0, sign_a = 1'b0;
   logic [1:0]  size_a = 2'd0;
   logic [8:0]  addr_a = 9'h0;
   logic [31:0] wdata_a = 32'h0;
   logic [31:0] rdata_a;
   logic        busy_a, done_a, err_a, mem_write_a;
   logic [8:0]  mem_raddr_a, mem_waddr_a;
   logic [7:0]  mem_data_out_a, mem_data_in_a;

   // instance B: read_latency = 3
   logic        req_b = 1'b0, write_b = 1'b0, sign_b = 1'b0;
   logic [1:0]  size_b = 2'd0;
   logic [8:0]  addr_b = 9'h0;
   logic [31:0] wdata_b = 32'h0;
   logic [31:0] rdata_b;
   logic        busy_b, done_b, err_b, mem_write_b;
   logic [8:0]  mem_raddr_b, mem_waddr_b;
   logic [7:0]  mem_data_out_b, mem_data_in_b;

   lsu_seq #(.addr_width(9), .read_latency(2)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .write(write_a), .size(size_a),
      .sign(sign_a), .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a),
      .busy(busy_a), .done(done_a), .err(err_a), .mem_raddr(mem_raddr_a),
      .mem_data_out(mem_data_out_a), .mem_waddr(mem_waddr_a),
      .mem_data_in(mem_data_in_a), .mem_write(mem_write_a)
   );

   lsu_seq #(.addr_width(9), .read_latency(3)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .write(write_b), .size(size_b),
      .sign(sign_b), .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b),
      .busy(busy_b), .done(done_b), .err(err_b), .mem_raddr(mem_raddr_b),
      .mem_data_out(mem_data_out_b), .mem_waddr(mem_waddr_b),
      .mem_data_in(mem_data_in_b), .mem_write(mem_write_b)
   );

   // Read memories: one pipeline register per latency edge beyond the first.
   logic [7:0] rom_a [512];
   logic [7:0] rom_b [512];
   logic [7:0] rd_a, rd_b1, rd_b2;
   always @(posedge clk) begin
      rd_a  <= rom_a[mem_raddr_a];
      rd_b1 <= rom_b[mem_raddr_b];
      rd_b2 <= rd_b1;
   end
   assign mem_data_out_a = rd_a;
   assign mem_data_out_b = rd_b2;

   // Strobe logs: {address, data} of every cycle with mem_write high.
   logic [16:0] obs_wr_a[$];
   logic [16:0] obs_wr_b[$];
   always @(posedge clk) begin
      if (mem_write_a) obs_wr_a.push_back({mem_waddr_a, mem_data_in_a});
      if (mem_write_b) obs_wr_b.push_back({mem_waddr_b, mem_data_in_b});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue_a(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [8:0] ad, input logic [31:0] wd);
      req_a = 1'b1; write_a = w; size_a = sz; sign_a = sg; addr_a = ad; wdata_a = wd;
      tick();
      req_a = 1'b0;
   endtask

   task automatic wait_done_a(output int cyc);
      cyc = 0;
      while (!done_a && cyc < 30) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      for (int i = 0; i < 512; i++) begin
         rom_a[i] = 8'h00;
         rom_b[i] = 8'h00;
      end
      rom_a[9'h010] = 8'h12; rom_a[9'h011] = 8'h34;
      rom_a[9'h012] = 8'h56; rom_a[9'h013] = 8'h78;
      rom_a[9'h020] = 8'h80;
      rom_a[9'h030] = 8'h80; rom_a[9'h031] = 8'h01;
      rom_b[9'h060] = 8'hA5; rom_b[9'h061] = 8'h3C;

      // reset state
      repeat (3) tick();
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_err", 32'(err_a), 32'd0);
      chk("rst_mem_write", 32'(mem_write_a), 32'd0);
      chk("rst_rdata", rdata_a, 32'h0);
      chk("rst_raddr", 32'(mem_raddr_a), 32'h0);
      chk("rst_waddr", 32'(mem_waddr_a), 32'h0);
      chk("rst_data_in", 32'(mem_data_in_a), 32'h0);
      reset = 1'b0;
      tick();

      // load long at 0x010, latency 2: address steps every 2 edges, done at +8
      issue_a(1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
      chk("ll_raddr0", 32'(mem_raddr_a), 32'h010);
      chk("ll_busy0", 32'(busy_a), 32'd1);
      for (int j = 1; j <= 8; j++) begin
         tick();
         chk($sformatf("ll_raddr%0d", j), 32'(mem_raddr_a),
             32'h010 + 32'((j / 2 > 3) ? 3 : j / 2));
         chk($sformatf("ll_done%0d", j), 32'(done_a), 32'(j == 8));
         chk($sformatf("ll_busy%0d", j), 32'(busy_a), 32'(j < 8));
      end
      chk("ll_rdata", rdata_a, 32'h12345678);
      chk("ll_err", 32'(err_a), 32'd0);
      tick();
      chk("ll_done_pulse", 32'(done_a), 32'd0);

      // sign/zero extension
      issue_a(1'b0, 2'd0, 1'b1, 9'h020, 32'h0);
      wait_done_a(cyc);
      chk("lb_s_cycles", 32'(cyc), 32'd2);
      chk("lb_s_rdata", rdata_a, 32'hFFFFFF80);
      issue_a(1'b0, 2'd0, 1'b0, 9'h020, 32'h0);
      wait_done_a(cyc);
      chk("lb_z_cycles", 32'(cyc), 32'd2);
      chk("lb_z_rdata", rdata_a, 32'h00000080);
      issue_a(1'b0, 2'd1, 1'b1, 9'h030, 32'h0);
      wait_done_a(cyc);
      chk("lw_s_cycles", 32'(cyc), 32'd4);
      chk("lw_s_rdata", rdata_a, 32'hFFFF8001);
      tick();

      // store word across the address wrap
      obs_wr_a.delete();
      issue_a(1'b1, 2'd1, 1'b0, 9'h1FF, 32'h0000BEEF);
      for (int j = 0; j <= 4; j++) begin
         if (j > 0) tick();
         chk($sformatf("sw_write%0d", j), 32'(mem_write_a), 32'(j % 2));
         chk($sformatf("sw_waddr%0d", j), 32'(mem_waddr_a), (j < 2) ? 32'h1FF : 32'h000);
         chk($sformatf("sw_din%0d", j), 32'(mem_data_in_a), (j < 2) ? 32'hBE : 32'hEF);
         chk($sformatf("sw_done%0d", j), 32'(done_a), 32'(j == 4));
      end
      chk("sw_strobes", 32'(obs_wr_a.size()), 32'd2);
      if (obs_wr_a.size() >= 2) begin
         chk("sw_wr0", 32'(obs_wr_a[0]), 32'({9'h1FF, 8'hBE}));
         chk("sw_wr1", 32'(obs_wr_a[1]), 32'({9'h000, 8'hEF}));
      end
      chk("sw_rdata_kept", rdata_a, 32'hFFFF8001);
      tick();

      // illegal size: done+err pulse, no memory activity
      obs_wr_a.delete();
      issue_a(1'b1, 2'd3, 1'b0, 9'h0AA, 32'h12345678);
      chk("il_done", 32'(done_a), 32'd1);
      chk("il_err", 32'(err_a), 32'd1);
      chk("il_busy", 32'(busy_a), 32'd0);
      tick();
      chk("il_done_clr", 32'(done_a), 32'd0);
      chk("il_err_clr", 32'(err_a), 32'd0);
      chk("il_raddr", 32'(mem_raddr_a), 32'h031);
      chk("il_waddr", 32'(mem_waddr_a), 32'h000);
      chk("il_strobes", 32'(obs_wr_a.size()), 32'd0);

      // reset in the cycle after the first strobe of a long store
      obs_wr_a.delete();
      issue_a(1'b1, 2'd2, 1'b0, 9'h040, 32'hA1B2C3D4);
      tick();
      chk("rs_strobe1", 32'(mem_write_a), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      chk("rs_busy", 32'(busy_a), 32'd0);
      chk("rs_done", 32'(done_a), 32'd0);
      chk("rs_write", 32'(mem_write_a), 32'd0);
      chk("rs_rdata", rdata_a, 32'h0);
      reset = 1'b0;
      repeat (6) tick();
      chk("rs_strobes", 32'(obs_wr_a.size()), 32'd1);
      if (obs_wr_a.size() >= 1) chk("rs_wr0", 32'(obs_wr_a[0]), 32'({9'h040, 8'hA1}));
      chk("rs_busy_after", 32'(busy_a), 32'd0);

      // latency 3: byte store, then word load issued in its done cycle
      req_b = 1'b1; write_b = 1'b1; size_b = 2'd0; sign_b = 1'b0;
      addr_b = 9'h050; wdata_b = 32'h0000005A;
      tick();
      req_b = 1'b0;
      tick();
      tick();
      chk("bb_store_done", 32'(done_b), 32'd1);
      chk("bb_store_busy", 32'(busy_b), 32'd0);
      req_b = 1'b1; write_b = 1'b0; size_b = 2'd1; sign_b = 1'b0;
      addr_b = 9'h060; wdata_b = 32'h0;
      tick();
      chk("bb_accept", 32'(busy_b), 32'd1);
      chk("bb_done0", 32'(done_b), 32'd0);
      req_b = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         // inputs change and req pulses while busy; none of it may take effect
         req_b = (j < 4) ? 1'(j % 2) : 1'b0;
         write_b = 1'b1; size_b = 2'd2; sign_b = 1'b1;
         addr_b = 9'h070; wdata_b = 32'hFFFFFFFF;
         tick();
         chk($sformatf("bb_done%0d", j), 32'(done_b), 32'(j == 6));
      end
      chk("bb_rdata", rdata_b, 32'h0000A53C);
      chk("bb_raddr", 32'(mem_raddr_b), 32'h061);
      chk("bb_err", 32'(err_b), 32'd0);
      repeat (3) tick();
      chk("bb_idle", 32'(busy_b), 32'd0);
      chk("bb_strobes", 32'(obs_wr_b.size()), 32'd1);
      if (obs_wr_b.size() >= 1) chk("bb_wr0", 32'(obs_wr_b[0]), 32'({9'h050, 8'h5A}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
